// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS
// pipeline. Owns the PC, drives the instruction-memory address directly from
// it, and captures the fetched word plus PC+4 into IF/ID. Redirects flush
// IF/ID to an all-zero bubble. Stalls freeze the PC and IF/ID together.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 branch_taken_i,
  input  logic [31:0]          branch_target_i,
  input  logic                 jump_i,
  input  logic [31:0]          jump_target_i,
  output logic [31:0]          imem_addr_o,
  input  logic [31:0]          imem_rdata_i,
  output logic [31:0]          if_id_instr_o,
  output logic [31:0]          if_id_pc4_o,
  output logic                 if_id_valid_o,
  output logic [CNT_WIDTH-1:0] fetch_count_o
);

  // Per-edge action, resolved in priority order below reset.
  typedef enum logic [1:0] {
    ACT_NORMAL,
    ACT_STALL,
    ACT_BRANCH,
    ACT_JUMP
  } action_e;

  // The low two bits of the reset PC are dropped so the PC is always word aligned.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  action_e              act;

  logic [31:0]          pc_q,    pc_d;
  logic [31:0]          instr_q, instr_d;
  logic [31:0]          pc4_q,   pc4_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;

  logic [31:0]          pc_plus4;

  // PC+4 wraps naturally modulo 2^32.
  assign pc_plus4 = pc_q + 32'd4;

  // Select the action for this edge: branch (older instruction) beats jump,
  // and any redirect overrides a stall request.
  always_comb begin
    act = ACT_NORMAL;
    if (branch_taken_i) begin
      act = ACT_BRANCH;
    end else if (jump_i) begin
      act = ACT_JUMP;
    end else if (stall_i) begin
      act = ACT_STALL;
    end
  end

  // Next-state for PC, IF/ID and the fetch counter; hold is the default.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (act)
      ACT_NORMAL: begin
        pc_d    = pc_plus4;
        instr_d = imem_rdata_i;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
      end
      ACT_BRANCH: begin
        pc_d    = {branch_target_i[31:2], 2'b00};
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
      ACT_JUMP: begin
        pc_d    = {jump_target_i[31:2], 2'b00};
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
      end
      ACT_STALL: begin
        pc_d    = pc_q;
      end
      default: begin
        pc_d    = pc_q;
      end
    endcase
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc4_o   = pc4_q;
  assign if_id_valid_o = valid_q;
  assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a table of per-cycle inputs with hand-computed
// post-edge state, then hand-written sequences for long stalls and the
// narrow-counter wrap.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic [31:0] imem_rdata_i;

  logic [31:0] imem_addr_o,   imem_addr_n;
  logic [31:0] if_id_instr_o, if_id_instr_n;
  logic [31:0] if_id_pc4_o,   if_id_pc4_n;
  logic        if_id_valid_o, if_id_valid_n;
  logic [31:0] fetch_count_o;
  logic [3:0]  fetch_count_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_pc4_o     (if_id_pc4_o),
    .if_id_valid_o   (if_id_valid_o),
    .fetch_count_o   (fetch_count_o)
  );

  // Narrow-counter copy driven by the same inputs, used for the wrap case.
  if_stage #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(4)) dut4 (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .imem_addr_o     (imem_addr_n),
    .imem_rdata_i    (imem_rdata_i),
    .if_id_instr_o   (if_id_instr_n),
    .if_id_pc4_o     (if_id_pc4_n),
    .if_id_valid_o   (if_id_valid_n),
    .fetch_count_o   (fetch_count_n)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] brt;
    logic        j;
    logic [31:0] jt;
    logic [31:0] rdata;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bt,
                       input logic jj, input logic [31:0] jt, input logic [31:0] rd);
    rst             = r;
    stall_i         = s;
    branch_taken_i  = b;
    branch_target_i = bt;
    jump_i          = jj;
    jump_target_i   = jt;
    imem_rdata_i    = rd;
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                rst  stl  br   brt           j    jt            rdata         pc            instr         pc4           v    cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        32'h0000_0000, 32'h0,        32'h0,        1'b0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8C08_0004, 32'h0000_0004, 32'h8C08_0004, 32'h4,        1'b1, 1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0109_5020, 32'h0000_0008, 32'h0109_5020, 32'h8,        1'b1, 2};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h3149_000C, 32'h0000_0008, 32'h0109_5020, 32'h8,        1'b1, 2};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h3149_000C, 32'h0000_0008, 32'h0109_5020, 32'h8,        1'b1, 2};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h3149_000C, 32'h0000_000C, 32'h3149_000C, 32'hC,        1'b1, 3};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'hAD2A_0008, 32'h0000_0010, 32'hAD2A_0008, 32'h10,       1'b1, 4};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0041, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0000_0040, 32'h0,        32'h0,        1'b0, 4};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h2002_0005, 32'h0000_0044, 32'h2002_0005, 32'h44,       1'b1, 5};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0000_0200, 32'h0,        32'h0,        1'b0, 5};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0000, 32'h0000_0204, 32'h0000_0000, 32'h204,      1'b1, 6};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFF, 32'h1111_1111, 32'hFFFF_FFFC, 32'h0,        32'h0,        1'b0, 6};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0800_0010, 32'h0000_0000, 32'h0800_0010, 32'h0,        1'b1, 7};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h2222_2222, 32'h0000_0000, 32'h0800_0010, 32'h0,        1'b1, 7};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0043, 32'h3333_3333, 32'h0000_0040, 32'h0,        32'h0,        1'b0, 7};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h4444_4444, 32'h0000_0040, 32'h0,        32'h0,        1'b0, 7};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 32'h0,        32'h5555_5555, 32'h0000_0000, 32'h0,        32'h0,        1'b0, 0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'hAAAA_5555, 32'h0000_0004, 32'hAAAA_5555, 32'h4,        1'b1, 1};

    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].brt,
            vecs[i].j, vecs[i].jt, vecs[i].rdata);
      step();
      chk("pc",    i, imem_addr_o,   vecs[i].e_pc);
      chk("instr", i, if_id_instr_o, vecs[i].e_instr);
      chk("pc4",   i, if_id_pc4_o,   vecs[i].e_pc4);
      chk("valid", i, {31'b0, if_id_valid_o}, {31'b0, vecs[i].e_valid});
      chk("cnt",   i, fetch_count_o, vecs[i].e_cnt);
      chk("cnt4",  i, {28'b0, fetch_count_n}, {28'b0, vecs[i].e_cnt[3:0]});
    end

    // Long stall: PC and IF/ID hold for every stalled cycle, then fetch resumes.
    // State entering: pc=4, instr=AAAA5555, pc4=4, cnt=1.
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h6666_0000 + n);
      step();
      chk("lstall_pc",    100 + n, imem_addr_o,   32'h4);
      chk("lstall_instr", 100 + n, if_id_instr_o, 32'hAAAA_5555);
      chk("lstall_cnt",   100 + n, fetch_count_o, 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h7777_0004);
    step();
    chk("resume_pc",    110, imem_addr_o,   32'h8);
    chk("resume_instr", 110, if_id_instr_o, 32'h7777_0004);
    chk("resume_pc4",   110, if_id_pc4_o,   32'h8);
    chk("resume_cnt",   110, fetch_count_o, 32'd2);

    // Narrow counter wrap: reset, then 16 fetches wrap a 4-bit count to 0.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    chk("wrap_rst", 200, {28'b0, fetch_count_n}, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0100_0000 + k);
      step();
      if (k == 15) chk("wrap_15", 215, {28'b0, fetch_count_n}, 32'd15);
    end
    chk("wrap_16",   216, {28'b0, fetch_count_n}, 32'd0);
    chk("wide_16",   217, fetch_count_o,          32'd16);
    chk("wrap_pc",   218, imem_addr_o,            32'd64);
    chk("wrap_pc4",  219, if_id_pc4_o,            32'd64);
    chk("wrap_inst", 220, if_id_instr_o,          32'h0100_0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Owns the PC and drives the instruction-memory address.
- Applies stall and redirect requests from later stages.
- Presents the fetched instruction word to the decode-stage control unit.
- Flushed slots are presented as 32'h0, which the control unit decodes as a nop (nopSignal=1, no register or memory writes).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- CNT_WIDTH, 32, width of the fetched-instruction performance counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  hazard-unit hold request (load-use); freezes PC and IF/ID.
- branch_taken_i  input  1  taken BEQ resolved downstream; redirect to branch_target_i.
- branch_target_i  input  32  branch target address.
- jump_i  input  1  J decoded in ID; redirect to jump_target_i.
- jump_target_i  input  32  jump target address.
- imem_addr_o  output  32  instruction-memory address; equals the PC (combinational).
- imem_rdata_i  input  32  instruction word at imem_addr_o, valid in the same cycle (asynchronous read).
- if_id_instr_o  output  32  IF/ID instruction register; feeds the decode control unit.
- if_id_pc4_o  output  32  IF/ID register holding PC+4 of that instruction.
- if_id_valid_o  output  1  1 = real fetched instruction, 0 = bubble.
- fetch_count_o  output  CNT_WIDTH  number of instructions accepted into IF/ID since reset.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC, if_id_instr_o=0, if_id_pc4_o=0, if_id_valid_o=0, fetch_count_o=0.
  - rst overrides every other input.
  - Reset asserted mid-stall or mid-redirect discards all pending state.
- imem_addr_o = pc at all times, with no register stage. Fetch latency: instruction at PC appears on if_id_instr_o one cycle after PC is presented.
- Per-edge priority (highest first): rst > branch_taken_i > jump_i > stall_i > normal.
- Normal:
  - pc <= pc+4.
  - if_id_instr_o <= imem_rdata_i, if_id_pc4_o <= pc+4, if_id_valid_o <= 1.
  - fetch_count_o += 1.
- Branch redirect:
  - pc <= {branch_target_i[31:2],2'b00}.
  - IF/ID flushed: instr=0, pc4=0, valid=0.
  - Counter unchanged.
- Jump redirect: same as branch redirect, using jump_target_i.
  - Branch and jump asserted together: branch wins. The older instruction is the branch.
- Redirect with stall_i=1 in the same cycle: redirect wins, stall ignored for that edge. The hazard unit must not request a stall that a redirect would void.
- Stall:
  - pc, if_id_instr_o, if_id_pc4_o, if_id_valid_o all hold.
  - Counter unchanged.
  - Stall for N consecutive cycles holds for N cycles, and fetch resumes at the held PC.
- Arithmetic:
  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000, no error).
  - fetch_count_o wraps modulo 2^CNT_WIDTH.
- Target bits [1:0] are ignored (forced word alignment).
- A fetched word of 32'h0 is still counted and marked valid=1. It is a real nop, distinct from a bubble.

Test Plan:
- Reset then free-run 4 cycles with imem returning 0x8C080004, 0x01095020, 0x3149000C, 0xAD2A0008 -> imem_addr_o 0,4,8,12; if_id_instr_o follows one cycle later; if_id_pc4_o 4,8,12,16; fetch_count_o=4.
- stall_i high 2 cycles at PC=8 -> imem_addr_o held 8, if_id_instr_o held; fetch_count_o frozen; PC=12 resumes the cycle after stall drops.
- branch_taken_i=1, branch_target_i=0x0000_0041, with jump_i=1, jump_target_i=0x100 and stall_i=1 in the same cycle -> next PC=0x40; IF/ID = 0 with valid=0; counter unchanged.
- jump_i=1, jump_target_i=0x200 -> next PC=0x200; bubble inserted; the following cycle fetches 0x200 with valid=1.
- Force PC=0xFFFF_FFFC via jump and run one normal cycle -> if_id_pc4_o=0, next PC=0; preset counter to all-ones (CNT_WIDTH=4) -> wraps to 0.
- Assert rst during an active stall with PC=0x40 -> next cycle PC=RESET_PC, all IF/ID outputs 0, counter 0.
